// File: rtl/byte_ram_ctrl.sv
// Byte-addressable little-endian data memory with a registered req/resp port,
// byte/halfword/word access, alignment/range fault detection and a clear-on-reset sweep.
module byte_ram_ctrl #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DEPTH_BYTES    = 256,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              rvalid,
  output logic [31:0]       rdata,
  output logic              fault
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [7:0]      mem [DEPTH_BYTES];

  logic            accept_c;
  logic            bad_c;
  logic [AW-1:0]   a_c;
  logic [7:0]      rbytes_c [4];
  logic [31:0]     load_c;
  logic [AW-1:0]   wr_base_c;
  logic [3:0]      wr_en_c;
  logic [31:0]     wr_data_c;

  assign accept_c = req && ready;
  assign a_c      = addr[AW-1:0];

  // Reject reserved size, misaligned sub-word/word accesses and out-of-range addresses
  always_comb begin
    bad_c = 1'b0;
    if ((addr >> AW) != '0) bad_c = 1'b1;
    case (size)
      2'b01:   if (addr[0] != 1'b0) bad_c = 1'b1;
      2'b10:   if (addr[1:0] != 2'b00) bad_c = 1'b1;
      2'b11:   bad_c = 1'b1;
      default: ;
    endcase
  end

  // Little-endian read of up to four bytes starting at the request address
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rbytes_c[i] = mem[a_c + AW'(i)];
    end
    case (size)
      2'b00:   load_c = sign_ext ? {{24{rbytes_c[0][7]}}, rbytes_c[0]}
                                 : {24'h000000, rbytes_c[0]};
      2'b01:   load_c = sign_ext ? {{16{rbytes_c[1][7]}}, rbytes_c[1], rbytes_c[0]}
                                 : {16'h0000, rbytes_c[1], rbytes_c[0]};
      default: load_c = {rbytes_c[3], rbytes_c[2], rbytes_c[1], rbytes_c[0]};
    endcase
  end

  // Byte-lane write port shared by the clear sweep and accepted stores
  always_comb begin
    wr_base_c = '0;
    wr_en_c   = 4'b0000;
    wr_data_c = 32'h0000_0000;
    if (state == CLEAR && !rst) begin
      wr_base_c = ptr;
      wr_en_c   = 4'b1111;
    end else if (accept_c && we && !bad_c) begin
      wr_base_c = a_c;
      wr_data_c = wdata;
      case (size)
        2'b00:   wr_en_c = 4'b0001;
        2'b01:   wr_en_c = 4'b0011;
        default: wr_en_c = 4'b1111;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en_c[i]) mem[wr_base_c + AW'(i)] <= wr_data_c[8*i +: 8];
    end
  end

  // Control FSM with registered response outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      ptr    <= '0;
      ready  <= 1'b0;
      rvalid <= 1'b0;
      rdata  <= 32'h0000_0000;
      fault  <= 1'b0;
    end else begin
      rvalid <= accept_c;
      fault  <= accept_c && bad_c;
      rdata  <= (accept_c && !we && !bad_c) ? load_c : 32'h0000_0000;
      case (state)
        CLEAR: begin
          ptr <= ptr + AW'(4);
          if (ptr == AW'(DEPTH_BYTES - 4)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN:     ready <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_ram_ctrl.sv
// Directed self-checking bench for byte_ram_ctrl with default parameters (256 bytes, clear on reset).
module tb_byte_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  byte_ram_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .size     (size),
    .sign_ext (sign_ext),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .fault    (fault)
  );

  // Drives one request for a single edge; caller sits just after a rising edge with ready = 1
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic rv, output logic [31:0] rd, output logic ft);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    rv = rvalid; rd = rdata; ft = fault;
  endtask

  task automatic test_reset;
    logic rv, ft;
    logic [31:0] rd;
    int n;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", fault); end
    rst = 1'b0;
    n = 0;
    while (!ready && n < 200) begin @(posedge clk); #1; n++; end
    total++; if (n !== 64) begin bad++; $display("FAIL clear_cycles: got %0d want 64", n); end
    issue(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rv, rd, ft);
    total++; if (rv !== 1'b1) begin bad++; $display("FAIL load40_rvalid: got %b want 1", rv); end
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL load40_rdata: got %h want 00000000", rd); end
    total++; if (ft !== 1'b0) begin bad++; $display("FAIL load40_fault: got %b want 0", ft); end
  endtask

  task automatic test_subword;
    logic rv, ft;
    logic [31:0] rd;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rv, rd, ft);
    total++; if (rv !== 1'b1 || ft !== 1'b0 || rd !== 32'h0)
      begin bad++; $display("FAIL store10_resp: got rv=%b ft=%b rd=%h want 1 0 00000000", rv, ft, rd); end
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, rv, rd, ft);
    total++; if (rd !== 32'h00000044) begin bad++; $display("FAIL byte10: got %h want 00000044", rd); end
    issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rv, rd, ft);
    total++; if (rd !== 32'h00000011) begin bad++; $display("FAIL byte13: got %h want 00000011", rd); end
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rv, rd, ft);
    total++; if (rd !== 32'h00001122) begin bad++; $display("FAIL half12_s: got %h want 00001122", rd); end
    issue(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAAF0, rv, rd, ft);
    total++; if (ft !== 1'b0) begin bad++; $display("FAIL store11_fault: got %b want 0", ft); end
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rv, rd, ft);
    total++; if (rd !== 32'hFFFFF044) begin bad++; $display("FAIL half10_s: got %h want FFFFF044", rd); end
    issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, rv, rd, ft);
    total++; if (rd !== 32'h0000F044) begin bad++; $display("FAIL half10_u: got %h want 0000F044", rd); end
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rv, rd, ft);
    total++; if (rd !== 32'hFFFFFFF0) begin bad++; $display("FAIL byte11_s: got %h want FFFFFFF0", rd); end
    issue(1'b0, 2'b10, 1'b1, 32'h10, 32'h0, rv, rd, ft);
    total++; if (rd !== 32'h1122F044) begin bad++; $display("FAIL word10: got %h want 1122F044", rd); end
  endtask

  task automatic test_back_to_back;
    req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h20; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    total++; if (rvalid !== 1'b1 || rdata !== 32'h0)
      begin bad++; $display("FAIL b2b_first: got rv=%b rd=%h want 1 00000000", rvalid, rdata); end
    we = 1'b0; wdata = 32'h0;
    @(posedge clk); #1;
    req = 1'b0;
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL b2b_second_rvalid: got %b want 1", rvalid); end
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL b2b_second_rdata: got %h want DEADBEEF", rdata); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL b2b_second_fault: got %b want 0", fault); end
    @(posedge clk); #1;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL b2b_idle_rvalid: got %b want 0", rvalid); end
  endtask

  task automatic test_faults;
    logic rv, ft;
    logic [31:0] rd;
    issue(1'b0, 2'b10, 1'b0, 32'h22, 32'h0, rv, rd, ft);
    total++; if (rv !== 1'b1 || ft !== 1'b1 || rd !== 32'h0)
      begin bad++; $display("FAIL word22: got rv=%b ft=%b rd=%h want 1 1 00000000", rv, ft, rd); end
    issue(1'b1, 2'b01, 1'b0, 32'h21, 32'h00005555, rv, rd, ft);
    total++; if (ft !== 1'b1) begin bad++; $display("FAIL half21_store: got %b want 1", ft); end
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rv, rd, ft);
    total++; if (rd !== 32'hDEADBEEF || ft !== 1'b0)
      begin bad++; $display("FAIL word20_kept: got rd=%h ft=%b want DEADBEEF 0", rd, ft); end
    issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, rv, rd, ft);
    total++; if (ft !== 1'b1 || rd !== 32'h0)
      begin bad++; $display("FAIL word100: got ft=%b rd=%h want 1 00000000", ft, rd); end
    issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, rv, rd, ft);
    total++; if (ft !== 1'b1) begin bad++; $display("FAIL size11: got %b want 1", ft); end
    issue(1'b0, 2'b00, 1'b0, 32'hFF, 32'h0, rv, rd, ft);
    total++; if (ft !== 1'b0 || rd !== 32'h0)
      begin bad++; $display("FAIL byteFF: got ft=%b rd=%h want 0 00000000", ft, rd); end
    issue(1'b1, 2'b00, 1'b0, 32'h100, 32'h000000AB, rv, rd, ft);
    total++; if (ft !== 1'b1) begin bad++; $display("FAIL store100: got %b want 1", ft); end
    issue(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, rv, rd, ft);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL byte0_untouched: got %h want 00000000", rd); end
  endtask

  task automatic test_reset_traffic;
    logic rv, ft;
    logic [31:0] rd;
    int n;
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h20;
    @(posedge clk); #1;
    req = 1'b0;
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL rt_pre_rvalid: got %b want 1", rvalid); end
    rst = 1'b1;
    #1;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL rt_rvalid_drop: got %b want 0", rvalid); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rt_ready_drop: got %b want 0", ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    while (!ready && n < 200) begin @(posedge clk); #1; n++; end
    total++; if (n !== 64) begin bad++; $display("FAIL rt_clear_cycles: got %0d want 64", n); end
    issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rv, rd, ft);
    total++; if (rd !== 32'h0 || rv !== 1'b1)
      begin bad++; $display("FAIL rt_word20: got rv=%b rd=%h want 1 00000000", rv, rd); end
  endtask

  task automatic test_not_ready;
    logic rv, ft;
    logic [31:0] rd;
    int n;
    issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h12345678, rv, rd, ft);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL nr_rvalid: got %b want 0", rvalid); end
    n = 1;
    while (!ready && n < 200) begin @(posedge clk); #1; n++; end
    total++; if (n !== 64) begin bad++; $display("FAIL nr_clear_cycles: got %0d want 64", n); end
    issue(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, rv, rd, ft);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL nr_word30: got %h want 00000000", rd); end
  endtask

  initial begin
    test_reset();
    test_subword();
    test_back_to_back();
    test_faults();
    test_reset_traffic();
    test_not_ready();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
